// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP camera capture block: pixel format
// encodings and the bytes-per-pixel lookup.
package dvp_pkg;

  typedef enum logic [1:0] {
    MODE_Y8     = 2'd0,
    MODE_RGB565 = 2'd1,
    MODE_RGB888 = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam logic [1:0] BPP_Y8     = 2'd1;
  localparam logic [1:0] BPP_RGB565 = 2'd2;
  localparam logic [1:0] BPP_RGB888 = 2'd3;

  localparam int PIX_W = 24;

  // The reserved encoding falls back to one byte per pixel.
  function automatic logic [1:0] bytes_per_px(input mode_e m);
    case (m)
      MODE_Y8:     bytes_per_px = BPP_Y8;
      MODE_RGB565: bytes_per_px = BPP_RGB565;
      MODE_RGB888: bytes_per_px = BPP_RGB888;
      default:     bytes_per_px = BPP_Y8;
    endcase
  endfunction

endpackage

// File: rtl/dvp_capture_multi_if.sv
// Captured pixel stream as seen downstream of the DVP capture block:
// the master drives it, a consumer or monitor observes it.
interface dvp_capture_multi_if #(
  parameter int XW = 12,
  parameter int YW = 12
);
  import dvp_pkg::*;

  logic              vsync;
  logic              href;
  logic              valid;
  logic [PIX_W-1:0]  data;
  logic [XW-1:0]     pix_x;
  logic [YW-1:0]     pix_y;

  modport master (output vsync, href, valid, data, pix_x, pix_y);
  modport slave  (input  vsync, href, valid, data, pix_x, pix_y);

endinterface

// File: rtl/dvp_edge_det.sv
// One-bit edge detector: remembers the previous sample and flags
// rising/falling transitions of the current one.
module dvp_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;
  assign fall_o = ~d_i & prev_q;

endmodule

// File: rtl/dvp_capture_multi.sv
// OV5640 DVP capture: waits out unstable start-up frames, then packs
// 1/2/3-byte pixels into a 24-bit strobed stream with x/y coordinates.
module dvp_capture_multi
  import dvp_pkg::*;
#(
  parameter int STABLE_FRAME = 10,
  parameter int XW           = 12,
  parameter int YW           = 12,
  parameter int FCW          = 16
) (
  input  logic              ov5640_pclk,
  input  logic              rst_n,
  input  logic              ov5640_vsync,
  input  logic              ov5640_href,
  input  logic [7:0]        ov5640_data,
  input  logic              cap_en,
  input  logic [1:0]        mode,
  output logic              dvp_vsync,
  output logic              dvp_href,
  output logic              dvp_valid,
  output logic [PIX_W-1:0]  dvp_data,
  output logic [XW-1:0]     pix_x,
  output logic [YW-1:0]     pix_y,
  output logic              frame_start,
  output logic [FCW-1:0]    frame_cnt,
  output logic              err_partial
);

  localparam logic [7:0] STAB = 8'(STABLE_FRAME);

  // Input stage d0
  logic             vs_d0_q, hr_d0_q;
  logic [7:0]       data_d0_q;

  always_ff @(posedge ov5640_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d0_q   <= 1'b0;
      hr_d0_q   <= 1'b0;
      data_d0_q <= '0;
    end else begin
      vs_d0_q   <= ov5640_vsync;
      hr_d0_q   <= ov5640_href;
      data_d0_q <= ov5640_data;
    end
  end

  logic vs_rise, vs_fall, hr_rise, hr_fall;

  dvp_edge_det u_vs_edge (
    .clk    (ov5640_pclk),
    .rst_n  (rst_n),
    .d_i    (vs_d0_q),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  dvp_edge_det u_hr_edge (
    .clk    (ov5640_pclk),
    .rst_n  (rst_n),
    .d_i    (hr_d0_q),
    .rise_o (hr_rise),
    .fall_o (hr_fall)
  );

  // Frame control and capture datapath state
  logic [7:0]        stab_q,      stab_d;
  logic              fvalid_q,    fvalid_d;
  mode_e             mode_q,      mode_d;
  logic              cap_en_q,    cap_en_d;
  logic              fs_q,        fs_d;
  logic [FCW-1:0]    fcnt_q,      fcnt_d;
  logic [1:0]        bcnt_q,      bcnt_d;
  logic [PIX_W-1:0]  acc_q,       acc_d;
  logic [XW-1:0]     x_q,         x_d;
  logic [YW-1:0]     y_q,         y_d;
  logic              vs_d1_q,     vs_d1_d;
  logic              hr_d1_q,     hr_d1_d;
  logic              valid_q,     valid_d;
  logic [PIX_W-1:0]  data_q,      data_d;
  logic [XW-1:0]     pix_x_q,     pix_x_d;
  logic [YW-1:0]     pix_y_q,     pix_y_d;
  logic              err_q,       err_d;

  logic              active;
  logic [1:0]        bpp;
  logic [1:0]        bcnt_base;
  logic [PIX_W-1:0]  acc_base;
  logic [PIX_W-1:0]  acc_shift;
  logic              take;

  assign active = fvalid_q & cap_en_q;
  assign bpp    = bytes_per_px(mode_q);
  // Bytes presented while vsync is high belong to no line and are dropped.
  assign take   = hr_d0_q & ~vs_d0_q;

  always_comb begin
    // NOTE: every _d gets a default first so no latch is inferred.
    stab_d    = stab_q;
    fvalid_d  = fvalid_q;
    mode_d    = mode_q;
    cap_en_d  = cap_en_q;
    fs_d      = 1'b0;
    fcnt_d    = fcnt_q;
    bcnt_d    = bcnt_q;
    acc_d     = acc_q;
    x_d       = x_q;
    y_d       = y_q;
    vs_d1_d   = vs_d0_q;
    hr_d1_d   = hr_d0_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    pix_x_d   = pix_x_q;
    pix_y_d   = pix_y_q;
    err_d     = 1'b0;

    // A fresh line or the end of vsync re-aligns byte packing to zero.
    bcnt_base = (hr_rise | vs_fall) ? 2'd0 : bcnt_q;
    acc_base  = (hr_rise | vs_fall) ? '0   : acc_q;
    acc_shift = {acc_base[PIX_W-9:0], data_d0_q};

    if (vs_rise) begin
      if (stab_q == STAB) fvalid_d = 1'b1;
      else                stab_d   = stab_q + 8'd1;
      mode_d   = mode_e'(mode);
      cap_en_d = cap_en;
      if (fvalid_d && cap_en) begin
        fs_d   = 1'b1;
        fcnt_d = fcnt_q + 1'b1;
      end
      bcnt_d = 2'd0;
      acc_d  = '0;
      x_d    = '0;
      y_d    = '0;
    end else if (active) begin
      if (take) begin
        if (bcnt_base == bpp - 2'd1) begin
          valid_d = 1'b1;
          data_d  = acc_shift;
          pix_x_d = x_q;
          pix_y_d = y_q;
          x_d     = (x_q == '1) ? x_q : x_q + 1'b1;
          bcnt_d  = 2'd0;
          acc_d   = '0;
        end else begin
          bcnt_d  = bcnt_base + 2'd1;
          acc_d   = acc_shift;
        end
      end else if (hr_fall && !vs_d0_q) begin
        err_d  = (bcnt_q != 2'd0);
        bcnt_d = 2'd0;
        acc_d  = '0;
        x_d    = '0;
        y_d    = (y_q == '1) ? y_q : y_q + 1'b1;
      end
    end
  end

  always_ff @(posedge ov5640_pclk or negedge rst_n) begin
    if (!rst_n) begin
      stab_q   <= '0;
      fvalid_q <= 1'b0;
      mode_q   <= MODE_RGB565;
      cap_en_q <= 1'b0;
      fs_q     <= 1'b0;
      fcnt_q   <= '0;
      bcnt_q   <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      vs_d1_q  <= 1'b0;
      hr_d1_q  <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      pix_x_q  <= '0;
      pix_y_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      stab_q   <= stab_d;
      fvalid_q <= fvalid_d;
      mode_q   <= mode_d;
      cap_en_q <= cap_en_d;
      fs_q     <= fs_d;
      fcnt_q   <= fcnt_d;
      bcnt_q   <= bcnt_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vs_d1_q  <= vs_d1_d;
      hr_d1_q  <= hr_d1_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      pix_x_q  <= pix_x_d;
      pix_y_q  <= pix_y_d;
      err_q    <= err_d;
    end
  end

  // While capture is inactive the stream is forced quiet; frame_cnt stays visible.
  assign dvp_vsync   = vs_d1_q & active;
  assign dvp_href    = hr_d1_q & active;
  assign dvp_valid   = valid_q & active;
  assign dvp_data    = active ? data_q  : '0;
  assign pix_x       = active ? pix_x_q : '0;
  assign pix_y       = active ? pix_y_q : '0;
  assign frame_start = fs_q & active;
  assign err_partial = err_q & active;
  assign frame_cnt   = fcnt_q;

endmodule
